// File: rtl/data_mem_unit_if.sv
// Load/store request and response bundle between the core datapath and the data memory.
// The core drives requests (master); the memory answers with data, stall and error (slave).
interface data_mem_unit_if #(
  parameter int width = 32
);
  logic             MemRead;
  logic             MemWrite;
  logic [2:0]       funct3;
  logic [width-1:0] ALUResult;
  logic [width-1:0] WriteData;
  logic [width-1:0] ReadData;
  logic             Stall;
  logic             AccessErr;

  modport master (
    output MemRead, MemWrite, funct3, ALUResult, WriteData,
    input  ReadData, Stall, AccessErr
  );

  modport slave (
    input  MemRead, MemWrite, funct3, ALUResult, WriteData,
    output ReadData, Stall, AccessErr
  );
endinterface

// File: rtl/data_mem_unit.sv
// Fixed-latency data memory: stalls the core for LATENCY cycles per access, then presents
// the formatted load word (or an error pulse) for exactly one DONE cycle.
module data_mem_unit #(
  parameter int width   = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic          CLK,
  input  logic          RST,
  data_mem_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic [AW+1:0]    addr_q;
  logic [31:0]      wdata_q;
  logic [2:0]       f3_q;
  logic             store_q, load_q;
  logic [width-1:0] rdata_q, rdata_d;
  logic             err_q;

  logic             req;
  logic [AW+1:0]    a_addr;
  logic [31:0]      a_wdata;
  logic [2:0]       a_f3;
  logic             a_store, a_load;
  logic [1:0]       off;
  logic [AW-1:0]    idx;
  logic             misalign, bad_f3, err;
  logic [3:0]       be;
  logic [31:0]      wlanes;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic             enter_done;
  logic             we;

  assign req = bus.MemRead | bus.MemWrite;

  // In IDLE the request is taken straight from the bus so a LATENCY=1 access can
  // complete on the same edge that captures it; afterwards the captured copy is used.
  always_comb begin
    a_addr  = addr_q;
    a_wdata = wdata_q;
    a_f3    = f3_q;
    a_store = store_q;
    a_load  = load_q;
    if (state_q == IDLE) begin
      a_addr  = bus.ALUResult[AW+1:0];
      a_wdata = bus.WriteData[31:0];
      a_f3    = bus.funct3;
      a_store = bus.MemWrite;
      a_load  = bus.MemRead & ~bus.MemWrite;
    end
  end

  assign off = a_addr[1:0];
  assign idx = a_addr[AW+1:2];

  always_comb begin
    misalign = ((a_f3[1:0] == 2'b01) && off[0]) ||
               ((a_f3[1:0] == 2'b10) && (off != 2'b00));
    if (a_store) begin
      bad_f3 = a_f3[2] | (a_f3[1:0] == 2'b11);
    end else begin
      bad_f3 = (a_f3 == 3'b011) | (a_f3[2:1] == 2'b11);
    end
    err = misalign | bad_f3;
  end

  always_comb begin
    be     = 4'b0000;
    wlanes = a_wdata;
    case (a_f3[1:0])
      2'b00: begin
        be     = 4'b0001 << off;
        wlanes = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be     = off[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{a_wdata[15:0]}};
      end
      2'b10: begin
        be     = 4'b1111;
        wlanes = a_wdata;
      end
      default: begin
        be     = 4'b0000;
        wlanes = a_wdata;
      end
    endcase
  end

  assign enter_done = ((state_q == IDLE) && req && (LATENCY == 1)) ||
                      ((state_q == WAIT) && (count_q == 4'd1));
  // RST gates the write so an access aborted by reset never lands in memory.
  assign we = RST & enter_done & a_store & ~err;

  // One byte-wide array per lane keeps byte-enable writes a plain RAM write port.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      always_ff @(posedge CLK) begin
        if (we && be[gi]) begin
          lane_mem[idx] <= wlanes[gi*8 +: 8];
        end
      end
      assign rd_word[gi*8 +: 8] = lane_mem[idx];
    end
  endgenerate

  assign rd_byte = rd_word[{off, 3'b000} +: 8];
  assign rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rdata_d = '0;
    if (a_load && !err) begin
      case (a_f3)
        3'b000:  rdata_d = width'($signed(rd_byte));
        3'b001:  rdata_d = width'($signed(rd_half));
        3'b010:  rdata_d = width'(rd_word);
        3'b100:  rdata_d = width'(rd_byte);
        3'b101:  rdata_d = width'(rd_half);
        default: rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          count_d = 4'(LATENCY - 1);
          state_d = (LATENCY > 1) ? WAIT : DONE;
        end
      end
      WAIT: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      load_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (state_q == IDLE && req) begin
        addr_q  <= bus.ALUResult[AW+1:0];
        wdata_q <= bus.WriteData[31:0];
        f3_q    <= bus.funct3;
        store_q <= bus.MemWrite;
        load_q  <= bus.MemRead & ~bus.MemWrite;
      end
      if (enter_done) begin
        rdata_q <= rdata_d;
        err_q   <= err;
      end
    end
  end

  assign bus.Stall     = RST & (((state_q == IDLE) & req) | (state_q == WAIT));
  assign bus.ReadData  = (state_q == DONE) ? rdata_q : '0;
  assign bus.AccessErr = (state_q == DONE) & err_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench: one DUT at LATENCY=2, a second at LATENCY=1, sharing clock and reset.
module tb_data_mem_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  data_mem_unit_if #(.width(32)) bus_a ();
  data_mem_unit_if #(.width(32)) bus_b ();

  data_mem_unit #(.width(32), .DEPTH(256), .LATENCY(2)) dut_a (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus_a)
  );

  data_mem_unit #(.width(32), .DEPTH(256), .LATENCY(1)) dut_b (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bit sel, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel) begin
      bus_b.MemRead = rd; bus_b.MemWrite = wr; bus_b.funct3 = f3;
      bus_b.ALUResult = addr; bus_b.WriteData = wdata;
    end else begin
      bus_a.MemRead = rd; bus_a.MemWrite = wr; bus_a.funct3 = f3;
      bus_a.ALUResult = addr; bus_a.WriteData = wdata;
    end
  endtask

  function automatic logic get_stall(input bit sel);
    return sel ? bus_b.Stall : bus_a.Stall;
  endfunction

  function automatic logic [31:0] get_rdata(input bit sel);
    return sel ? bus_b.ReadData : bus_a.ReadData;
  endfunction

  function automatic logic get_err(input bit sel);
    return sel ? bus_b.AccessErr : bus_a.AccessErr;
  endfunction

  // Runs one access; quiet=0 if ReadData/AccessErr were nonzero outside the DONE cycle.
  task automatic access(input bit sel, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int stalls, output logic [31:0] rdata, output logic err,
                        output bit quiet);
    stalls = 0;
    quiet  = 1'b1;
    @(negedge clk);
    drive(sel, rd, wr, f3, addr, wdata);
    #1;
    while (get_stall(sel) === 1'b1 && stalls < 40) begin
      stalls++;
      if (get_rdata(sel) !== 32'd0 || get_err(sel) !== 1'b0) quiet = 1'b0;
      @(negedge clk);
      #1;
    end
    rdata = get_rdata(sel);
    err   = get_err(sel);
    drive(sel, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    if (get_rdata(sel) !== 32'd0 || get_err(sel) !== 1'b0) quiet = 1'b0;
    $display("txn dut=%0d rd=%b wr=%b f3=%b addr=%h wdata=%h stalls=%0d rdata=%h err=%b",
             sel, rd, wr, f3, addr, wdata, stalls, rdata, err);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'd0);
    #12;
    checks++;
    if (bus_a.Stall !== 1'b0 || bus_a.ReadData !== 32'd0 || bus_a.AccessErr !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs stall=%b rdata=%h err=%b required 0/0/0",
               bus_a.Stall, bus_a.ReadData, bus_a.AccessErr);
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word;
    int st; logic [31:0] rd; logic er; bit q;
    access(1'b0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, st, rd, er, q);
    checks++;
    if (st !== 2 || er !== 1'b0 || q !== 1'b1) begin
      errors++; $display("FAIL sw_stall stalls=%0d err=%b quiet=%b required 2/0/1", st, er, q);
    end
    access(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0, st, rd, er, q);
    checks++;
    if (st !== 2 || q !== 1'b1) begin
      errors++; $display("FAIL lw_stall stalls=%0d quiet=%b required 2/1", st, q);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_data got %h required deadbeef", rd);
    end
  endtask

  task automatic test_byte;
    int st; logic [31:0] rd; logic er; bit q;
    access(1'b0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, st, rd, er, q);
    access(1'b0, 1'b0, 1'b1, 3'b000, 32'h13, 32'h80, st, rd, er, q);
    access(1'b0, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, st, rd, er, q);
    checks++;
    if (rd !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_sext got %h required ffffff80", rd);
    end
    access(1'b0, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, st, rd, er, q);
    checks++;
    if (rd !== 32'h00000080) begin
      errors++; $display("FAIL lbu_zext got %h required 00000080", rd);
    end
    access(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, st, rd, er, q);
    checks++;
    if (rd !== 32'h80000000) begin
      errors++; $display("FAIL sb_lane got %h required 80000000", rd);
    end
  endtask

  task automatic test_half;
    int st; logic [31:0] rd; logic er; bit q;
    access(1'b0, 1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, st, rd, er, q);
    access(1'b0, 1'b0, 1'b1, 3'b001, 32'h22, 32'h00001234, st, rd, er, q);
    access(1'b0, 1'b1, 1'b0, 3'b001, 32'h22, 32'h0, st, rd, er, q);
    checks++;
    if (rd !== 32'h00001234) begin
      errors++; $display("FAIL lh_upper got %h required 00001234", rd);
    end
    access(1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, st, rd, er, q);
    checks++;
    if (rd !== 32'h1234F00D) begin
      errors++; $display("FAIL sh_lane got %h required 1234f00d", rd);
    end
    access(1'b0, 1'b1, 1'b0, 3'b001, 32'h20, 32'h0, st, rd, er, q);
    checks++;
    if (rd !== 32'hFFFFF00D) begin
      errors++; $display("FAIL lh_sext got %h required fffff00d", rd);
    end
    access(1'b0, 1'b1, 1'b0, 3'b101, 32'h20, 32'h0, st, rd, er, q);
    checks++;
    if (rd !== 32'h0000F00D) begin
      errors++; $display("FAIL lhu_zext got %h required 0000f00d", rd);
    end
  endtask

  task automatic test_misaligned;
    int st; logic [31:0] rd; logic er; bit q;
    access(1'b0, 1'b1, 1'b0, 3'b010, 32'h21, 32'h0, st, rd, er, q);
    checks++;
    if (st !== 2 || er !== 1'b1 || rd !== 32'd0 || q !== 1'b1) begin
      errors++;
      $display("FAIL lw_misalign stalls=%0d err=%b rdata=%h quiet=%b required 2/1/0/1", st, er, rd, q);
    end
    access(1'b0, 1'b0, 1'b1, 3'b001, 32'h23, 32'h0000BEEF, st, rd, er, q);
    checks++;
    if (st !== 2 || er !== 1'b1 || q !== 1'b1) begin
      errors++; $display("FAIL sh_misalign stalls=%0d err=%b quiet=%b required 2/1/1", st, er, q);
    end
    access(1'b0, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, st, rd, er, q);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      errors++; $display("FAIL illegal_load err=%b rdata=%h required 1/0", er, rd);
    end
    access(1'b0, 1'b0, 1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, st, rd, er, q);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL illegal_store err=%b required 1", er);
    end
    access(1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, st, rd, er, q);
    checks++;
    if (rd !== 32'h1234F00D || er !== 1'b0) begin
      errors++; $display("FAIL misalign_nowrite got %h err=%b required 1234f00d/0", rd, er);
    end
  endtask

  task automatic test_both_and_wrap;
    int st; logic [31:0] rd; logic er; bit q;
    access(1'b0, 1'b1, 1'b1, 3'b010, 32'h0, 32'h55, st, rd, er, q);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0 || st !== 2) begin
      errors++; $display("FAIL both_req rdata=%h err=%b stalls=%0d required 0/0/2", rd, er, st);
    end
    access(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, st, rd, er, q);
    checks++;
    if (rd !== 32'h00000055) begin
      errors++; $display("FAIL both_store got %h required 00000055", rd);
    end
    access(1'b0, 1'b0, 1'b1, 3'b010, 32'h404, 32'h0BADF00D, st, rd, er, q);
    access(1'b0, 1'b1, 1'b0, 3'b010, 32'h4, 32'h0, st, rd, er, q);
    checks++;
    if (rd !== 32'h0BADF00D) begin
      errors++; $display("FAIL addr_wrap got %h required 0badf00d", rd);
    end
  endtask

  task automatic test_reset_mid_access;
    int st; logic [31:0] rd; logic er; bit q;
    access(1'b0, 1'b0, 1'b1, 3'b010, 32'h8, 32'h11111111, st, rd, er, q);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 3'b010, 32'h8, 32'hAA);
    @(negedge clk);
    #1;
    checks++;
    if (bus_a.Stall !== 1'b1) begin
      errors++; $display("FAIL wait_stall got %b required 1", bus_a.Stall);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.Stall !== 1'b0) begin
      errors++; $display("FAIL reset_abort_stall got %b required 0", bus_a.Stall);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus_a.Stall !== 1'b0 || bus_a.ReadData !== 32'd0 || bus_a.AccessErr !== 1'b0) begin
      errors++; $display("FAIL reset_release stall=%b rdata=%h err=%b required 0/0/0",
                         bus_a.Stall, bus_a.ReadData, bus_a.AccessErr);
    end
    access(1'b0, 1'b1, 1'b0, 3'b010, 32'h8, 32'h0, st, rd, er, q);
    checks++;
    if (rd !== 32'h11111111 || st !== 2) begin
      errors++; $display("FAIL reset_discard got %h stalls=%0d required 11111111/2", rd, st);
    end
  endtask

  task automatic test_latency1;
    int st; logic [31:0] rd; logic er; bit q;
    access(1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, st, rd, er, q);
    checks++;
    if (st !== 1 || q !== 1'b1) begin
      errors++; $display("FAIL l1_sw_stall stalls=%0d quiet=%b required 1/1", st, q);
    end
    access(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, st, rd, er, q);
    checks++;
    if (st !== 1 || rd !== 32'hDEADBEEF || q !== 1'b1) begin
      errors++; $display("FAIL l1_lw stalls=%0d rdata=%h quiet=%b required 1/deadbeef/1", st, rd, q);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_both_and_wrap();
    test_reset_mid_access();
    test_latency1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
